ibex_instr_capture_fifo: RTL
============================

IBEX_INSTR_CAPTURE_FIFO -- requirements
Module: ibex_instr_capture_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of PC, instruction and branch-target fields.
REQ-002 Parameter DEPTH, default 8: number of entries; power of two, >= 2.
REQ-003 clk_i  input  1: sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1: asynchronous, active-low reset.
REQ-005 valid_id_i  input  1: ID stage holds a valid instruction.
REQ-006 stall_id_i  input  1: ID stage stalled this cycle.
REQ-007 err_id_i, is_compressed_id_i, branch_taken_id_i, jump_set_id_i  input  1 each: per-instruction flags.
REQ-008 instr_compressed_id_i  input  16: raw compressed encoding.
REQ-009 instr_id_i, pc_id_i, branch_target_id_i  input  DATA_WIDTH each: instruction, PC, branch/jump target.
REQ-010 flush_i  input  1: synchronous clear of all stored entries.
REQ-011 out_valid_o  output  1: head entry available.
REQ-012 out_ready_i  input  1: consumer accepts head entry.
REQ-013 out_entry_o  output  packed entry type: head entry fields, plus seq field.
REQ-014 count_o  output  $clog2(DEPTH)+1: current occupancy.
REQ-015 overflow_o  output  1: sticky, at least one capture dropped.
REQ-016 drop_cnt_o  output  16: number of dropped captures, saturating.

Function
REQ-017 Capture event = valid_id_i && !stall_id_i; at most one per cycle.
REQ-018 Entry stores all ID inputs; branch_target stored as zero when neither branch_taken_id_i nor jump_set_id_i is set.
REQ-019 Each captured entry gets a 32-bit seq: capture count since reset/flush, starting at 0, wraps at 2^32.
REQ-020 Pop occurs when out_valid_o && out_ready_i; out_entry_o stable while out_valid_o && !out_ready_i.
REQ-021 Latency: entry captured in cycle N is visible at out_entry_o in cycle N+1 if buffer was empty; no combinational in-to-out path.
REQ-022 out_valid_o = (count_o != 0).
REQ-023 Push and pop in same cycle: both performed, count unchanged, including when full.
REQ-024 Capture when full with no pop: entry dropped, overflow_o set, drop_cnt_o incremented, saturating at 16'hFFFF; seq still increments so gaps are visible downstream.
REQ-025 Read/write pointers wrap modulo DEPTH.
REQ-026 flush_i has priority over push and pop: next cycle count_o=0, seq restarts at 0, pointers reset; overflow_o and drop_cnt_o are not cleared by flush.
REQ-027 Capture coincident with flush_i is discarded and not counted as a drop.

Reset
REQ-028 Asynchronous reset sets count_o=0, out_valid_o=0, overflow_o=0, drop_cnt_o=0, seq=0, pointers=0.
REQ-029 Reset mid-operation discards all entries; entry storage need not be reset.

Configuration
REQ-030 Macro IBEX_INSTR_CAPTURE_DUMMY_FILTER_EN, when defined, adds input dummy_instr_id_i (1 bit); captures with dummy_instr_id_i=1 are neither stored nor counted in seq nor counted as drops.
REQ-031 Without IBEX_INSTR_CAPTURE_DUMMY_FILTER_EN, the port is absent and every capture event is stored.

Structure
REQ-032 Package ibex_instr_capture_pkg holds the packed entry typedef (parametrised by width via DATA_WIDTH-sized fields at default 32) and the drop-counter width constant.
REQ-033 Sub-module ibex_instr_capture_ptr (pointer/occupancy counter with wrap and flush) is the natural split; storage and capture logic stay in the top module.

Verification
REQ-034 Empty buffer, one capture pc=0x80, out_ready_i=1: out_valid_o high exactly next cycle, entry pc=0x80, seq=0, then count_o returns to 0.
REQ-035 DEPTH=8, 10 captures, out_ready_i=0: count_o=8, overflow_o=1, drop_cnt_o=2; draining yields seq 0..7.
REQ-036 Full buffer, capture plus pop in the same cycle: count_o stays 8; new entry emerges last with correct seq.
REQ-037 Capture with stall_id_i=1: no entry. Capture with branch_taken_id_i=0, jump_set_id_i=0, target=0x1234: stored target=0.
REQ-038 Flush with 5 entries held and simultaneous capture: count_o=0 next cycle; next capture has seq=0; drop_cnt_o unchanged.
REQ-039 IBEX_INSTR_CAPTURE_DUMMY_FILTER_EN defined, alternating dummy/real captures x4: 2 entries stored with seq 0,1; drop_cnt_o=0.

Source files
------------

// File: rtl/ibex_instr_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_instr_capture_pkg
// Description : Shared types and constants for the ID-stage instruction
//               capture FIFO. Holds the packed entry layout presented at the
//               FIFO output, plus the drop-counter and sequence widths.
//               Entry data fields are CAPTURE_DATA_W (32) bits wide. A
//               narrower DATA_WIDTH on the top module is zero-extended into
//               them.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_instr_capture_pkg;

    localparam int unsigned CAPTURE_DATA_W = 32;
    localparam int unsigned DROP_CNT_W     = 16;
    localparam int unsigned SEQ_W          = 32;

    typedef struct packed {
        logic                      err;
        logic                      is_compressed;
        logic                      branch_taken;
        logic                      jump_set;
        logic [15:0]               instr_compressed;
        logic [CAPTURE_DATA_W-1:0] instr;
        logic [CAPTURE_DATA_W-1:0] pc;
        logic [CAPTURE_DATA_W-1:0] branch_target;
        logic [SEQ_W-1:0]          seq;
    } capture_entry_t;

endpackage
`default_nettype wire

// File: rtl/ibex_instr_capture_ptr.sv
`default_nettype none
// ============================================================================
// Module      : ibex_instr_capture_ptr
// Description : Read/write pointers and occupancy counter for the capture
//               FIFO. Pointers wrap modulo DEPTH (DEPTH is a power of two).
//               flush_i takes priority and returns everything to zero.
// Ports       : clk_i, rst_ni  - clock, async active-low reset
//               flush_i        - synchronous clear
//               push_i, pop_i  - qualified write / read strobes
//               wr_ptr_o, rd_ptr_o, count_o, full_o
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_instr_capture_ptr #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Natural overflow of the PTR_W-bit add gives modulo-DEPTH wrap.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
    assign full_o   = (count_q == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/ibex_instr_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ibex_instr_capture_fifo
// Description : Captures every instruction leaving the ID stage
//               (valid && !stall) into a DEPTH-entry FIFO. Each capture is
//               tagged with a 32-bit sequence number. Captures that arrive
//               while the FIFO is full and not draining are dropped, but
//               still consume a sequence number so gaps are visible
//               downstream. overflow_o is sticky and drop_cnt_o saturates.
//               Neither is cleared by flush_i.
// Ports       : clk_i, rst_ni            - clock, async active-low reset
//               *_id_i                   - ID-stage instruction fields
//               flush_i                  - clear stored entries and seq
//               out_valid_o/out_ready_i  - head handshake
//               out_entry_o              - head entry (incl. seq)
//               count_o                  - occupancy
//               overflow_o, drop_cnt_o   - drop reporting
// Options     : IBEX_INSTR_CAPTURE_DUMMY_FILTER_EN adds dummy_instr_id_i.
//               Dummy instructions are ignored entirely: they are not
//               stored, not sequenced and not counted as drops.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_instr_capture_fifo
    import ibex_instr_capture_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_id_i,
    input  logic                  stall_id_i,
    input  logic                  err_id_i,
    input  logic                  is_compressed_id_i,
    input  logic                  branch_taken_id_i,
    input  logic                  jump_set_id_i,
    input  logic [15:0]           instr_compressed_id_i,
    input  logic [DATA_WIDTH-1:0] instr_id_i,
    input  logic [DATA_WIDTH-1:0] pc_id_i,
    input  logic [DATA_WIDTH-1:0] branch_target_id_i,
`ifdef IBEX_INSTR_CAPTURE_DUMMY_FILTER_EN
    input  logic                  dummy_instr_id_i,
`endif
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output capture_entry_t        out_entry_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  overflow_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    logic             w_capture;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic [CNT_W-1:0] w_count;
    capture_entry_t   w_entry;

    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    capture_entry_t        mem_q [DEPTH];

`ifdef IBEX_INSTR_CAPTURE_DUMMY_FILTER_EN
    assign w_capture = valid_id_i & ~stall_id_i & ~dummy_instr_id_i;
`else
    assign w_capture = valid_id_i & ~stall_id_i;
`endif

    assign w_pop = (w_count != '0) & out_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push = w_capture & ~flush_i & (~w_full | w_pop);
    assign w_drop = w_capture & ~flush_i & w_full & ~w_pop;

    always_comb begin
        w_entry                  = '0;
        w_entry.err              = err_id_i;
        w_entry.is_compressed    = is_compressed_id_i;
        w_entry.branch_taken     = branch_taken_id_i;
        w_entry.jump_set         = jump_set_id_i;
        w_entry.instr_compressed = instr_compressed_id_i;
        w_entry.instr            = CAPTURE_DATA_W'(instr_id_i);
        w_entry.pc               = CAPTURE_DATA_W'(pc_id_i);
        // Target is only meaningful for taken branches and jumps.
        // Zero it otherwise so stale target values never leak downstream.
        if (branch_taken_id_i || jump_set_id_i) begin
            w_entry.branch_target = CAPTURE_DATA_W'(branch_target_id_i);
        end
        w_entry.seq = seq_q;
    end

    always_comb begin
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            seq_d = '0;
        end else if (w_capture) begin
            seq_d = seq_q + SEQ_W'(1);
        end
        if (w_drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is intentionally not reset. The pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[w_wr_ptr] <= w_entry;
        end
    end

    ibex_instr_capture_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .push_i   (w_push),
        .pop_i    (w_pop),
        .wr_ptr_o (w_wr_ptr),
        .rd_ptr_o (w_rd_ptr),
        .count_o  (w_count),
        .full_o   (w_full)
    );

    assign out_entry_o = mem_q[w_rd_ptr];
    assign out_valid_o = (w_count != '0);
    assign count_o     = w_count;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule
`default_nettype wire
